// File: rtl/div_err_monitor.sv
// div_err_monitor: error-statistics monitor for the 16/8 approximate array divider.
// Recomputes each in-range sample with an 8-step restoring divider and accumulates
// quotient error metrics with saturating counters.
// Optional build macro: DIV_ERR_REM_EN adds remainder-mismatch counting (rem_err_cnt);
// without it rem_err_cnt is tied to 0.
module div_err_monitor #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      dividend,
  input  logic [7:0]       divisor,
  input  logic [7:0]       approx_q,
  input  logic [7:0]       approx_r,
  input  logic             stat_clr,
  output logic             done,
  output logic [ACC_W-1:0] sample_cnt,
  output logic [ACC_W-1:0] skip_cnt,
  output logic [ACC_W-1:0] err_cnt,
  output logic [ACC_W-1:0] ed_sum,
  output logic [7:0]       ed_max,
  output logic [ACC_W-1:0] rem_err_cnt
);

  typedef enum logic [1:0] {IDLE, CALC, UPDATE} state_t;

  state_t     state, state_nxt;
  logic [7:0] lo_q;     // low dividend byte, shifted out MSB first
  logic [7:0] d_q;
  logic [7:0] aq_q;
  logic [7:0] pr_q;     // partial remainder; holds the exact remainder after CALC
  logic [7:0] q_q;
  logic [2:0] it_q;
  logic       skip_q;

  logic       accept;
  logic       range_skip;
  logic [8:0] trial;
  logic [8:0] diff;
  logic [7:0] ed;

  assign in_ready   = (state == IDLE);
  assign done       = (state == UPDATE);
  assign accept     = in_valid && in_ready;
  // Quotient only fits in 8 bits when the high dividend byte is below the divisor.
  assign range_skip = (divisor == 8'd0) || (dividend[15:8] >= divisor);
  // pr < divisor always holds, so the trial stays within 9-bit signed range.
  assign trial      = {pr_q, lo_q[7]} - {1'b0, d_q};
  assign diff       = {1'b0, q_q} - {1'b0, aq_q};
  assign ed         = diff[8] ? (~diff[7:0] + 8'd1) : diff[7:0];

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: skips bypass CALC, valid samples take 8 iterations.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = range_skip ? UPDATE : CALC;
      CALC:    if (it_q == 3'd7) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch and restoring-division datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q   <= '0;
      d_q    <= '0;
      aq_q   <= '0;
      pr_q   <= '0;
      q_q    <= '0;
      it_q   <= '0;
      skip_q <= 1'b0;
    end else if (accept) begin
      lo_q   <= dividend[7:0];
      d_q    <= divisor;
      aq_q   <= approx_q;
      pr_q   <= dividend[15:8];
      q_q    <= '0;
      it_q   <= '0;
      skip_q <= range_skip;
    end else if (state == CALC) begin
      pr_q <= trial[8] ? {pr_q[6:0], lo_q[7]} : trial[7:0];
      q_q  <= {q_q[6:0], ~trial[8]};
      lo_q <= {lo_q[6:0], 1'b0};
      it_q <= it_q + 3'd1;
    end
  end

  // Quotient statistics; a coincident clear discards the sample's contribution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      skip_cnt   <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
    end else if (stat_clr) begin
      sample_cnt <= '0;
      skip_cnt   <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
    end else if (state == UPDATE) begin
      if (skip_q) begin
        skip_cnt <= sat_add(skip_cnt, {{(ACC_W-1){1'b0}}, 1'b1});
      end else begin
        sample_cnt <= sat_add(sample_cnt, {{(ACC_W-1){1'b0}}, 1'b1});
        ed_sum     <= sat_add(ed_sum, {{(ACC_W-8){1'b0}}, ed});
        err_cnt    <= sat_add(err_cnt, {{(ACC_W-1){1'b0}}, (ed != 8'd0)});
        if (ed > ed_max) ed_max <= ed;
      end
    end
  end

`ifdef DIV_ERR_REM_EN
  logic [7:0]       ar_q;
  logic [ACC_W-1:0] rem_err_q;

  // Remainder comparison against the exact remainder left in pr after CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_q      <= '0;
      rem_err_q <= '0;
    end else begin
      if (accept) ar_q <= approx_r;
      if (stat_clr)
        rem_err_q <= '0;
      else if (state == UPDATE && !skip_q)
        rem_err_q <= sat_add(rem_err_q, {{(ACC_W-1){1'b0}}, (ar_q != pr_q)});
    end
  end

  assign rem_err_cnt = rem_err_q;
`else
  logic unused_approx_r;
  assign unused_approx_r = ^approx_r;
  assign rem_err_cnt     = '0;
`endif

endmodule
